// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared types and helpers for the instruction prefetch queue.
//   - boundary decoder state encoding
//   - width helpers (bytes per bus word, byte-PC width)
//   - FIFO entry layout {instr, len, pc}
//   - pf_need_next: does the instruction continue past the current byte?
package prefetch_pkg;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2,
        B3 = 2'd3
    } bnd_state_t;

    // Widest byte PC the queue entry can carry.
    localparam int PF_PC_MAX = 32;

    typedef struct packed {
        logic [31:0]          instr;
        logic [2:0]           len;
        logic [PF_PC_MAX-1:0] pc;
    } pf_entry_t;

    function automatic int pf_bytes(input int bus_w);
        return bus_w / 8;
    endfunction

    function automatic int pf_pc_w(input int adr_w, input int bus_w);
        return adr_w + $clog2(bus_w / 8);
    endfunction

    // 1 = the instruction needs another byte after the one seen in state s.
    // In B2 the decision was already taken from byte1 (latched as szw).
    function automatic logic pf_need_next(input bnd_state_t s,
                                          input logic [7:0] b,
                                          input logic       szw);
        logic nxt;
        nxt = 1'b0;
        case (s)
            B0:      nxt = b[1] | b[0];
            B1:      nxt = b[1];
            B2:      nxt = szw;
            default: nxt = 1'b0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pf_fifo.sv
// pf_fifo: synchronous shift-register FIFO with registered head output.
//   clk, rst_n : clock, async active-low reset (all storage zeroed)
//   clr        : synchronous empty, wins over push/pop
//   push, din  : write; accepted when not full, or when full with a pop
//   pop        : remove head when not empty
//   dout       : head entry (straight from a flop)
//   empty/full : occupancy flags
module pf_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH_LG = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << DEPTH_LG;

    logic [WIDTH-1:0]  slot [DEPTH];
    logic [DEPTH_LG:0] count;
    logic [DEPTH_LG:0] wr_pos;
    logic              do_pop;
    logic              do_push;

    assign empty   = (count == '0);
    assign full    = (count == (DEPTH_LG+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Slot 0 is always the head; a push lands behind the last live entry,
    // which moves down one place when the same cycle also pops.
    assign wr_pos  = do_pop ? count - 1'b1 : count;
    assign dout    = slot[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= '0;
            end
        end else if (clr) begin
            count <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH-1; i++) begin
                    slot[i] <= slot[i+1];
                end
            end
            if (do_push) begin
                slot[wr_pos[DEPTH_LG-1:0]] <= din;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetch unit.
// Fetches bus words (max two reads in flight), assembles 1-4 byte instructions
// one byte per cycle and queues {instr, len, pc} for the execution unit.
//   clk, rst_n        : clock, async active-low reset
//   mem_req/mem_adr   : read request and word address (held until granted)
//   mem_gnt           : request accepted
//   mem_rvalid/rdata  : in-order read return
//   instr_vld/rdy     : queue head handshake
//   instr/len/pc      : head instruction (byte0 in [31:24]), length, byte PC
//   flush/flush_pc    : redirect to any byte address
//
// Boundary decoder states:
//   state | meaning
//   B0    | expecting byte0 of a new instruction
//   B1    | byte0 held, expecting byte1
//   B2    | byte0-1 held, expecting byte2
//   B3    | byte0-2 held, expecting byte3
module prefetch_queue
    import prefetch_pkg::*;
#(
    parameter  int BUS_W    = 16,
    parameter  int ADR_W    = 20,
    parameter  int DEPTH_LG = 3,
    parameter  int RESET_PC = 0,
    localparam int BYTES    = pf_bytes(BUS_W),
    localparam int OFF_W    = $clog2(BYTES),
    localparam int PC_W     = pf_pc_w(ADR_W, BUS_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req,
    output logic [ADR_W-1:0] mem_adr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [BUS_W-1:0] mem_rdata,
    output logic             instr_vld,
    input  logic             instr_rdy,
    output logic [31:0]      instr,
    output logic [2:0]       instr_len,
    output logic [PC_W-1:0]  instr_pc,
    input  logic             flush,
    input  logic [PC_W-1:0]  flush_pc
);

    logic             started;
    logic [ADR_W-1:0] adr;
    logic [1:0]       outstanding;
    logic [1:0]       discard;
    logic [1:0]       out_n;
    logic             ret;

    // Return register in front of the word buffer.
    logic             in_vld;
    logic [BUS_W-1:0] in_data;

    // Two-entry word buffer, wb[0] is the head.
    logic [BUS_W-1:0] wb [2];
    logic [1:0]       wb_cnt;
    logic             wb_pop;

    logic [OFF_W-1:0] byte_idx;
    logic [PC_W-1:0]  asm_pc;
    bnd_state_t       state;
    logic [7:0]       b0, b1, b2;
    logic             szw;

    logic [7:0]       cur_byte;
    logic             head_vld;
    logic             cont;
    logic             can_push;
    logic             consume;
    logic             emit;

    pf_entry_t        ent;
    pf_entry_t        head;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;

    // A return with nothing outstanding is a protocol error and is ignored.
    assign ret      = mem_rvalid && (outstanding != 2'd0);
    assign out_n    = outstanding + 2'(mem_gnt) - 2'(ret);

    // Words in flight, in the return register and in the buffer all count
    // against the two-word budget, so the buffer can never overflow.
    assign mem_req  = started && !flush &&
                      ((3'(wb_cnt) + 3'(in_vld) + 3'(outstanding)) < 3'd2);
    assign mem_adr  = adr;

    assign head_vld = (wb_cnt != 2'd0);
    assign cur_byte = wb[0][{byte_idx, 3'b000} +: 8];
    assign cont     = pf_need_next(state, cur_byte, szw);
    assign fifo_pop = instr_vld && instr_rdy && !flush;
    assign can_push = !fifo_full || fifo_pop;
    // A byte that completes an instruction is only taken if it can be queued.
    assign consume  = !flush && head_vld && (cont || can_push);
    assign emit     = !flush && head_vld && !cont && can_push;
    assign wb_pop   = consume && (byte_idx == OFF_W'(BYTES-1));

    always_comb begin
        ent       = '0;
        ent.pc    = PF_PC_MAX'(asm_pc);
        ent.len   = 3'd1;
        ent.instr = {cur_byte, 24'h0};
        case (state)
            B1: begin
                ent.len   = 3'd2;
                ent.instr = {b0, cur_byte, 16'h0};
            end
            B2: begin
                ent.len   = 3'd3;
                ent.instr = {b0, b1, cur_byte, 8'h0};
            end
            B3: begin
                ent.len   = 3'd4;
                ent.instr = {b0, b1, b2, cur_byte};
            end
            default: ;
        endcase
    end

    // Fetch, return path, word buffer and assembly pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            adr         <= ADR_W'(RESET_PC >> OFF_W);
            outstanding <= 2'd0;
            discard     <= 2'd0;
            in_vld      <= 1'b0;
            in_data     <= '0;
            wb[0]       <= '0;
            wb[1]       <= '0;
            wb_cnt      <= 2'd0;
            byte_idx    <= OFF_W'(RESET_PC);
            asm_pc      <= PC_W'(RESET_PC);
        end else begin
            started     <= 1'b1;
            outstanding <= out_n;
            if (flush) begin
                // Everything still in flight after this edge is stale.
                discard  <= out_n;
                adr      <= flush_pc[PC_W-1:OFF_W];
                in_vld   <= 1'b0;
                wb_cnt   <= 2'd0;
                byte_idx <= flush_pc[OFF_W-1:0];
                asm_pc   <= flush_pc;
            end else begin
                if (mem_gnt) begin
                    adr <= adr + 1'b1;
                end
                if (ret && (discard != 2'd0)) begin
                    discard <= discard - 1'b1;
                end
                in_vld <= ret && (discard == 2'd0);
                if (ret) begin
                    in_data <= mem_rdata;
                end

                case ({wb_pop, in_vld})
                    2'b01: begin
                        wb[wb_cnt[0]] <= in_data;
                        wb_cnt        <= wb_cnt + 1'b1;
                    end
                    2'b10: begin
                        wb[0]  <= wb[1];
                        wb_cnt <= wb_cnt - 1'b1;
                    end
                    2'b11: begin
                        wb[0] <= (wb_cnt == 2'd1) ? in_data : wb[1];
                        wb[1] <= in_data;
                    end
                    default: ;
                endcase

                if (consume) begin
                    byte_idx <= wb_pop ? '0 : byte_idx + 1'b1;
                end
                if (emit) begin
                    asm_pc <= asm_pc + PC_W'(ent.len);
                end
            end
        end
    end

    // Boundary decoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= B0;
            b0    <= 8'h0;
            b1    <= 8'h0;
            b2    <= 8'h0;
            szw   <= 1'b0;
        end else if (flush) begin
            state <= B0;
            b0    <= 8'h0;
            b1    <= 8'h0;
            b2    <= 8'h0;
            szw   <= 1'b0;
        end else if (consume) begin
            if (cont) begin
                case (state)
                    B0: begin
                        b0    <= cur_byte;
                        state <= B1;
                    end
                    B1: begin
                        b1    <= cur_byte;
                        szw   <= cur_byte[0];
                        state <= B2;
                    end
                    B2: begin
                        b2    <= cur_byte;
                        state <= B3;
                    end
                    default: state <= B0;
                endcase
            end else begin
                state <= B0;
            end
        end
    end

    pf_fifo #(
        .WIDTH    ($bits(pf_entry_t)),
        .DEPTH_LG (DEPTH_LG)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (emit),
        .din   (ent),
        .pop   (fifo_pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign instr_vld = !fifo_empty;
    assign instr     = head.instr;
    assign instr_len = head.len;
    assign instr_pc  = head.pc[PC_W-1:0];

    a_rvalid_outstanding : assert property (
        @(posedge clk) disable iff (!rst_n) mem_rvalid |-> (outstanding != 2'd0)
    );

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: a memory model with a grant/return queue drives the
// DUT; every popped instruction is compared with a decode of the byte stream
// computed straight from memory contents and the length rules.
module tb_prefetch_queue;

    localparam int BUS_W = 16;
    localparam int ADR_W = 20;
    localparam int PC_W  = 21;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mem_req;
    logic [ADR_W-1:0] mem_adr;
    logic             mem_gnt = 1'b0;
    logic             mem_rvalid = 1'b0;
    logic [BUS_W-1:0] mem_rdata = '0;
    logic             instr_vld;
    logic             instr_rdy = 1'b0;
    logic [31:0]      instr;
    logic [2:0]       instr_len;
    logic [PC_W-1:0]  instr_pc;
    logic             flush = 1'b0;
    logic [PC_W-1:0]  flush_pc = '0;

    always #5 clk = ~clk;

    prefetch_queue #(
        .BUS_W    (BUS_W),
        .ADR_W    (ADR_W),
        .DEPTH_LG (3),
        .RESET_PC (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_adr    (mem_adr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .instr_vld  (instr_vld),
        .instr_rdy  (instr_rdy),
        .instr      (instr),
        .instr_len  (instr_len),
        .instr_pc   (instr_pc),
        .flush      (flush),
        .flush_pc   (flush_pc)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory contents ----------------
    int          mode = 0;
    logic [31:0] seed = 32'h5a17_c3e1;

    function automatic logic [15:0] mem_word(input logic [19:0] a);
        logic [31:0] h;
        h = ({12'h0, a} * 32'h9E37_79B1) ^ seed;
        case (mode)
            0:       return (a == 20'h0) ? 16'h0300 : 16'h0000;
            1:       return 16'h0202;
            2:       return 16'h0101;
            3:       return a[0] ? 16'h2211 : 16'h0303;
            default: return h[23:8];
        endcase
    endfunction

    function automatic logic [7:0] byte_at(input logic [PC_W-1:0] b);
        logic [15:0] w;
        w = mem_word(b[PC_W-1:1]);
        return b[0] ? w[15:8] : w[7:0];
    endfunction

    // Reference: length from byte0/byte1 bits, unused bytes zero.
    task automatic ref_decode(input logic [PC_W-1:0] pc, output logic [31:0] ins,
                              output logic [2:0] len);
        logic [7:0] c0, c1, c2, c3;
        c0 = byte_at(pc);
        c1 = byte_at(pc + 21'd1);
        c2 = byte_at(pc + 21'd2);
        c3 = byte_at(pc + 21'd3);
        if (c0[1:0] == 2'b00)  len = 3'd1;
        else if (!c1[1])       len = 3'd2;
        else if (!c1[0])       len = 3'd3;
        else                   len = 3'd4;
        ins = {c0, (len > 3'd1) ? c1 : 8'h0, (len > 3'd2) ? c2 : 8'h0,
               (len > 3'd3) ? c3 : 8'h0};
    endtask

    // ---------------- bench state ----------------
    logic [ADR_W-1:0] q[$];
    int               lat_mode = 0;     // 0 next cycle, 1 random, 2 hold
    int               rdy_mode = 1;     // 0 low, 1 high, 2 random
    int               gnt_mode = 0;     // 0 always, 1 random
    logic             flush_next = 1'b0;
    logic [PC_W-1:0]  flush_pc_next = '0;
    int               mode_next = 0;
    logic             auto_flush = 1'b0;
    logic             rand_flush = 1'b0;
    int               auto_hits = 0;
    logic             post_flush = 1'b0;
    logic [ADR_W-1:0] flush_word = '0;
    logic [PC_W-1:0]  exp_pc = '0;
    int               pops = 0;
    int               cyc = 0;
    int               first_rv = -1;
    int               first_vld = -1;

    task automatic cycle();
        logic [31:0] ins;
        logic [2:0]  len;
        @(negedge clk);
        cyc++;
        if (post_flush) begin
            check("flush_vld", instr_vld, 1'b0);
            check("flush_adr", mem_adr, flush_word);
            post_flush = 1'b0;
        end
        if (instr_vld && first_vld < 0) first_vld = cyc;

        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (q.size() > 0 &&
            (lat_mode == 0 || (lat_mode == 1 && $urandom_range(0, 2) != 0))) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(q.pop_front());
            if (first_rv < 0) first_rv = cyc;
        end

        case (rdy_mode)
            0:       instr_rdy = 1'b0;
            1:       instr_rdy = 1'b1;
            default: instr_rdy = ($urandom_range(0, 3) != 0);
        endcase

        flush = 1'b0;
        if (flush_next) begin
            flush      = 1'b1;
            flush_pc   = flush_pc_next;
            mode       = mode_next;
            flush_next = 1'b0;
        end else if ((auto_flush && mem_rvalid && instr_vld && instr_rdy) ||
                     (rand_flush && $urandom_range(0, 39) == 0)) begin
            flush    = 1'b1;
            flush_pc = PC_W'($urandom);
            if (auto_flush) auto_hits++;
        end

        #1;
        mem_gnt = mem_req && (gnt_mode == 0 || $urandom_range(0, 1) == 1);
        if (mem_gnt) q.push_back(mem_adr);

        if (flush) begin
            exp_pc     = flush_pc;
            post_flush = 1'b1;
            flush_word = flush_pc[PC_W-1:1];
        end else if (instr_vld && instr_rdy) begin
            ref_decode(exp_pc, ins, len);
            check("pop_pc", instr_pc, exp_pc);
            check("pop_len", instr_len, len);
            check("pop_instr", instr, ins);
            exp_pc = exp_pc + PC_W'(len);
            pops++;
        end
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        int target;
        int k;
        target = pops + n;
        k = 0;
        while (pops < target && k < budget) begin
            cycle();
            k++;
        end
        check(tag, (pops >= target), 1'b1);
    endtask

    task automatic do_flush(input logic [PC_W-1:0] pc, input int m);
        flush_next    = 1'b1;
        flush_pc_next = pc;
        mode_next     = m;
    endtask

    initial begin
        int p0;
        int k;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_req", mem_req, 1'b0);
        check("rst_vld", instr_vld, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_len", instr_len, 3'd0);
        check("rst_pc", instr_pc, 21'h0);
        check("rst_adr", mem_adr, 20'h0);
        rst_n = 1'b1;

        // T1: words 0x0300, 0x0000, ... from reset, next-cycle memory
        mode = 0; lat_mode = 0; rdy_mode = 1; gnt_mode = 0;
        wait_pops("t1_pops", 6, 200);
        check("t1_latency", 64'(first_vld - first_rv), 64'd3);

        // T2..T4: fixed patterns
        do_flush(21'h0, 1);
        wait_pops("t2_pops", 10, 200);
        do_flush(21'h0, 2);
        wait_pops("t3_pops", 10, 200);
        do_flush(21'h0, 3);
        wait_pops("t4_pops", 6, 200);

        // T5: consumer stalls until the queue and word buffer are full
        rdy_mode = 0;
        do_flush(21'h10, 2);
        repeat (60) cycle();
        check("t5_vld", instr_vld, 1'b1);
        check("t5_req", mem_req, 1'b0);
        rdy_mode = 1;
        p0 = pops;
        repeat (8) cycle();
        check("t5_drain8", 64'(pops - p0), 64'd8);
        wait_pops("t5_pops", 10, 200);

        // T6: redirect to byte 5 with two reads outstanding
        mode = 4;
        lat_mode = 2;
        do_flush(21'h40, 4);
        k = 0;
        while (q.size() < 2 && k < 20) begin
            cycle();
            k++;
        end
        check("t6_two_out", 64'(q.size()), 64'd2);
        do_flush(21'h5, 4);
        cycle();
        lat_mode = 1;
        wait_pops("t6_pops", 10, 300);

        // T7: flush coincident with pop, return and likely push
        lat_mode = 0;
        auto_flush = 1'b1;
        k = 0;
        while (auto_hits < 5 && k < 400) begin
            cycle();
            k++;
        end
        auto_flush = 1'b0;
        check("t7_hits", (auto_hits >= 5), 1'b1);
        wait_pops("t7_pops", 10, 300);

        // T8: random latency, grants, ready and redirects
        lat_mode = 1; rdy_mode = 2; gnt_mode = 1; rand_flush = 1'b1;
        repeat (3000) cycle();
        rand_flush = 1'b0;
        wait_pops("t8_pops", 5, 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
